// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, PC width and the fetch sequencer state.
package cpu_pkg;

  localparam int PC_W = 32;

  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd3;
  localparam logic [5:0] OP_BGT  = 6'd6;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_HALTED  = 2'd3
  } fetchState_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and the control unit.
interface instr_fetch_unit_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr;
  logic [5:0]      OpCode;
  logic            instr_valid;
  logic            instr_ready;
  logic [PC_W-1:0] pc_out;
  logic            resolve_valid;
  logic            Jump;
  logic            BranchEq;
  logic            BranchGr;
  logic            alu_zero;
  logic            alu_gt;
  logic            halted;
  logic [31:0]     instr_count;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr, OpCode, instr_valid, pc_out, halted, instr_count,
    input  imem_ack, imem_rdata, instr_ready, resolve_valid, Jump, BranchEq, BranchGr,
    input  alu_zero, alu_gt
  );

  // Memory / control unit side
  modport slave (
    input  imem_req, imem_addr, instr, OpCode, instr_valid, pc_out, halted, instr_count,
    output imem_ack, imem_rdata, instr_ready, resolve_valid, Jump, BranchEq, BranchGr,
    output alu_zero, alu_gt
  );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC resolution: jump, then BEQ, then BGT, else sequential.
import cpu_pkg::*;

module next_pc_calc (
  input  logic [PC_W-1:0] pc,
  input  logic [31:0]     instr,
  input  logic            jump,
  input  logic            branchEq,
  input  logic            branchGr,
  input  logic            aluZero,
  input  logic            aluGt,
  output logic [PC_W-1:0] nextPc
);

  // Word-aligned signed branch displacement from the 16-bit immediate.
  function automatic logic signed [PC_W-1:0] branchOffset(input logic [15:0] imm);
    logic signed [PC_W-1:0] ext;
    ext = PC_W'($signed(imm));
    return ext <<< 2;
  endfunction

  logic [PC_W-1:0]        pc4;
  logic signed [PC_W-1:0] offset;
  logic [PC_W-1:0]        branchTarget;
  logic [PC_W-1:0]        jumpTarget;

  assign pc4          = pc + PC_W'(4);
  assign offset       = branchOffset(instr[15:0]);
  assign branchTarget = pc4 + $unsigned(offset);
  assign jumpTarget   = {pc4[31:28], instr[25:0], 2'b00};

  // Priority select of the next PC; all arithmetic wraps modulo 2^32.
  always_comb begin
    nextPc = pc4;
    if (jump)                      nextPc = jumpTarget;
    else if (branchEq && aluZero)  nextPc = branchTarget;
    else if (branchGr && aluGt)    nextPc = branchTarget;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch / issue / resolve sequencer feeding OpCode to the control unit.
import cpu_pkg::*;

module instr_fetch_unit #(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]      HALT_OP  = OP_HALT
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_unit_if.master  bus
);

  fetchState_e     state;
  fetchState_e     nextState;
  logic            rstQ;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pcOut;
  logic [PC_W-1:0] nextPc;
  logic [31:0]     ir;
  logic [31:0]     instrCount;
  logic            fetchReq;
  logic            issueValid;
  logic            haltFlag;
  logic            ackTake;
  logic            acceptTake;
  logic            resolveTake;
  logic            isHaltWord;

  // An ack only counts while the request is actually up, so a cycle that
  // follows a sampled reset cannot capture a stale memory response.
  assign ackTake     = (state == ST_FETCH) && !rstQ && bus.imem_ack;
  assign acceptTake  = (state == ST_ISSUE) && bus.instr_ready;
  assign resolveTake = (state == ST_RESOLVE) && bus.resolve_valid;
  assign isHaltWord  = (bus.imem_rdata[31:26] == HALT_OP);

  next_pc_calc u_nextPc (
    .pc       (pc),
    .instr    (ir),
    .jump     (bus.Jump),
    .branchEq (bus.BranchEq),
    .branchGr (bus.BranchGr),
    .aluZero  (bus.alu_zero),
    .aluGt    (bus.alu_gt),
    .nextPc   (nextPc)
  );

  // State register; rstQ remembers that the previous edge sampled reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      rstQ  <= 1'b1;
    end else begin
      state <= nextState;
      rstQ  <= 1'b0;
    end
  end

  // Next-state decode.
  always_comb begin
    nextState = state;
    unique case (state)
      ST_FETCH: begin
        if (ackTake) nextState = isHaltWord ? ST_HALTED : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (acceptTake) nextState = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        if (resolveTake) nextState = ST_FETCH;
      end
      ST_HALTED: nextState = ST_HALTED;
      default:   nextState = ST_FETCH;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    fetchReq   = 1'b0;
    issueValid = 1'b0;
    haltFlag   = 1'b0;
    unique case (state)
      ST_FETCH:   fetchReq   = !rstQ;
      ST_ISSUE:   issueValid = 1'b1;
      ST_HALTED:  haltFlag   = 1'b1;
      default:    ;
    endcase
  end

  // PC, instruction register, issued-PC and accepted-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      ir         <= '0;
      pcOut      <= '0;
      instrCount <= '0;
    end else begin
      if (ackTake) begin
        ir    <= bus.imem_rdata;
        pcOut <= pc;
      end
      if (acceptTake)  instrCount <= instrCount + 32'd1;
      if (resolveTake) pc         <= nextPc;
    end
  end

  assign bus.imem_req    = fetchReq;
  assign bus.imem_addr   = pc;
  assign bus.instr       = ir;
  assign bus.OpCode      = ir[31:26];
  assign bus.instr_valid = issueValid;
  assign bus.pc_out      = pcOut;
  assign bus.halted      = haltFlag;
  assign bus.instr_count = instrCount;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multi-cycle instruction fetch and issue sequencer. It drives the `OpCode` side of the control-unit interface: it fetches 32-bit words from instruction memory over a req/ack handshake, holds each word in an instruction register, and presents `OpCode` to the control unit with a valid/ready handshake. It then resolves the next PC from the control unit's `Jump`, `BranchEq` and `BranchGr` outputs and the ALU flags, and supports a halt opcode.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `HALT_OP`, 6'h3F: opcode that stops fetching.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `imem_req`, out, 1: fetch request.
- `imem_addr`, out, 32: fetch address (PC).
- `imem_ack`, in, 1: memory data valid this cycle.
- `imem_rdata`, in, 32: instruction word.
- `instr`, out, 32: instruction register (IR).
- `OpCode`, out, 6: `instr[31:26]`, to the control unit.
- `instr_valid`, out, 1: IR issued.
- `instr_ready`, in, 1: downstream accepts.
- `pc_out`, out, 32: PC of the issued instruction.
- `resolve_valid`, in, 1: control and flags below are valid.
- `Jump`, `BranchEq`, `BranchGr`, in, 1 each: from the control unit.
- `alu_zero`, `alu_gt`, in, 1 each: ALU compare flags.
- `halted`, out, 1: halt state reached.
- `instr_count`, out, 32: instructions accepted downstream.

## Operation
- States:
  - FETCH: `imem_req`=1, `imem_addr`=PC. On `imem_ack`, capture `imem_rdata` into IR. Go to HALTED if the opcode equals `HALT_OP`, else go to ISSUE.
  - ISSUE: `instr_valid`=1. IR and `pc_out` are stable. On `instr_valid && instr_ready`, increment `instr_count` and go to RESOLVE.
  - RESOLVE: wait for `resolve_valid`, load the next PC, go to FETCH.
  - HALTED: all requests stay low and `halted`=1 until `rst`.
- Next-PC priority, where `pc4 = PC+4`:
  1. `Jump` gives `{pc4[31:28], instr[25:0], 2'b00}`.
  2. `BranchEq && alu_zero` gives `pc4 + (sext(instr[15:0]) << 2)`.
  3. `BranchGr && alu_gt` gives the same branch target.
  4. Otherwise `pc4`.
- All PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- `instr_count` wraps at 2^32.
- The following are ignored:
  - `imem_ack` outside FETCH.
  - `instr_ready` outside ISSUE.
  - `resolve_valid` outside RESOLVE.
- A HALT word is never issued and is not counted.
- Reset values:
  - state = FETCH, PC = `RESET_PC`.
  - IR = 0, `OpCode` = 0, `pc_out` = 0.
  - `instr_valid` = 0, `halted` = 0, `instr_count` = 0.
  - `imem_req` = 0 during the reset cycle.
- Reset mid-operation, in any state:
  - An ack arriving in the reset cycle is discarded.
  - The next cycle restarts FETCH at `RESET_PC`.

## Timing
- `imem_req`, `imem_addr` and `instr_valid` are decoded from registered state and PC only. They have no combinational path from inputs.
- `imem_req` is high in the first cycle after `rst` falls. It holds with a stable address until ack, for any memory latency.
- Ack in cycle N means IR and `OpCode` update at N+1, with `instr_valid`=1 at N+1.
- `instr_valid` stays high until accepted. It drops in the cycle after the handshake.
- RESOLVE is entered the cycle after the handshake. `resolve_valid` arriving in that cycle starts FETCH the next cycle.
- Minimum throughput is 3 cycles per instruction, with zero-wait memory and immediate ready and resolve.
- `instr_count` increments in the cycle after the handshake.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants: `OP_J` = 2, `OP_BEQ` = 3, `OP_BGT` = 6, `OP_HALT` = 6'h3F;
  - the fetch state enum;
  - `PC_W` = 32.
- One combinational sub-module, `next_pc_calc`, takes PC, IR and the control/flag inputs and produces the next PC. The FSM, IR and counter live in `instr_fetch_unit`.

## Test plan
- Reset: assert `rst` for 2 cycles, with a stuck `imem_ack`=1 during reset.
  - Expect `imem_addr`=0 and `imem_req` rising the cycle after `rst` falls.
  - Expect all outputs at reset values and no capture.
- Jump: memory returns 32'h0800_0010 at PC 0 after 3 wait cycles. Hold `instr_ready`=0 for 2 cycles, then assert it, then resolve with `Jump`=1.
  - Expect `OpCode`=2 to be held stable while not ready.
  - Expect `instr_count`=1 and the next `imem_addr`=32'h40.
- Branch taken and not taken at PC 32'h40 with word 32'h1800_0003 (`OpCode`=6):
  - `BranchGr`=1, `alu_gt`=1 gives next PC 32'h50.
  - `alu_gt`=0 gives 32'h44.
  - Word 32'h0C00_FFFF with `BranchEq`=1 and `alu_zero`=1 gives 32'h40.
- Halt: fetch 32'hFC00_0000.
  - Expect `halted`=1, `instr_valid` never asserted and `imem_req` staying 0.
  - Expect `instr_count` unchanged.
  - `rst` returns to FETCH at `RESET_PC`.
- Wrap and mid-operation reset:
  - With `RESET_PC`=32'hFFFF_FFFC, a sequential resolve gives the next `imem_addr`=0.
  - Asserting `rst` in ISSUE drops `instr_valid` the next cycle and restarts the fetch at `RESET_PC`.
